output_circuit: RTL and testbench

- Parallel-to-serial output stage of the 64-point FFT processor, complementing the serial-to-parallel input stage.
- Accepts one 8-word block (D0..D7, 32-bit complex words: real [31:16], imaginary [15:0]) per load handshake from the datapath controller.
- Streams the words out one per cycle with valid/ready backpressure, and optionally swaps real/imaginary for IFFT mode.
- Holds a shadow bank, so the next block can be loaded while the current block shifts out.
- Flags the last word of each block and of each 64-point frame (8 blocks).

---
 rtl/output_circuit.sv | 130 +++++++++++++
 tb/tb_output_circuit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_circuit.sv
// Parallel-to-serial FFT output stage: 8-word blocks out one per beat,
// with a shadow bank for gapless streaming and optional IFFT re/im swap.
module output_circuit #(
    parameter int DATA_WIDTH       = 32,
    parameter int BLOCKS_PER_FRAME = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  load,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] D0,
    input  logic [DATA_WIDTH-1:0] D1,
    input  logic [DATA_WIDTH-1:0] D2,
    input  logic [DATA_WIDTH-1:0] D3,
    input  logic [DATA_WIDTH-1:0] D4,
    input  logic [DATA_WIDTH-1:0] D5,
    input  logic [DATA_WIDTH-1:0] D6,
    input  logic [DATA_WIDTH-1:0] D7,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  Q_valid,
    input  logic                  Q_ready,
    output logic                  block_last,
    output logic                  frame_last
);

    localparam int HW = DATA_WIDTH / 2;
    localparam int BW = (BLOCKS_PER_FRAME > 1) ? $clog2(BLOCKS_PER_FRAME) : 1;
    localparam logic [BW-1:0] BLK_LAST = BW'(BLOCKS_PER_FRAME - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                r_state;
    logic [2:0]            r_idx;
    logic [BW-1:0]         r_blk;
    logic [DATA_WIDTH-1:0] r_shift  [8];
    logic [DATA_WIDTH-1:0] r_shadow [8];
    logic                  r_shift_mode;
    logic                  r_shadow_mode;
    logic                  r_shadow_full;

    logic [DATA_WIDTH-1:0] w_d [8];
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_accept;
    logic                  w_beat;
    logic                  w_end;

    assign w_d[0] = D0;
    assign w_d[1] = D1;
    assign w_d[2] = D2;
    assign w_d[3] = D3;
    assign w_d[4] = D4;
    assign w_d[5] = D5;
    assign w_d[6] = D6;
    assign w_d[7] = D7;

    assign load_ready = !r_shadow_full;
    assign Q_valid    = (r_state == SHIFT);
    assign w_accept   = load && load_ready;
    assign w_beat     = Q_valid && Q_ready;
    assign w_end      = w_beat && (r_idx == 3'd7);

    // Output swap is purely combinational off held state, so Q is stable under stall
    assign w_word = r_shift[r_idx];
    always_comb begin
        Q = '0;
        if (Q_valid) begin
            Q = r_shift_mode ? {w_word[HW-1:0], w_word[DATA_WIDTH-1:HW]} : w_word;
        end
    end

    assign block_last = Q_valid && (r_idx == 3'd7);
    assign frame_last = block_last && (r_blk == BLK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_blk         <= '0;
            r_shift_mode  <= 1'b0;
            r_shadow_mode <= 1'b0;
            r_shadow_full <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_shift[i]  <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift      <= w_d;
                        r_shift_mode <= mode;
                        r_idx        <= '0;
                        r_state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_end) begin
                        r_idx <= '0;
                        r_blk <= (r_blk == BLK_LAST) ? '0 : r_blk + 1'b1;
                        if (r_shadow_full) begin
                            r_shift       <= r_shadow;
                            r_shift_mode  <= r_shadow_mode;
                            r_shadow_full <= 1'b0;
                        end else if (w_accept) begin
                            r_shift      <= w_d;
                            r_shift_mode <= mode;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        if (w_beat) begin
                            r_idx <= r_idx + 3'd1;
                        end
                        if (w_accept) begin
                            r_shadow      <= w_d;
                            r_shadow_mode <= mode;
                            r_shadow_full <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_circuit.sv
// Bench for output_circuit: constant vector table, directed corner sequences,
// and random traffic checked against a word-queue reference model.
module tb_output_circuit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        load;
    logic        load_ready;
    logic [31:0] d [8];
    logic [31:0] Q;
    logic        Q_valid;
    logic        Q_ready;
    logic        block_last;
    logic        frame_last;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    output_circuit #(.DATA_WIDTH(32), .BLOCKS_PER_FRAME(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .load(load), .load_ready(load_ready),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
        .Q(Q), .Q_valid(Q_valid), .Q_ready(Q_ready),
        .block_last(block_last), .frame_last(frame_last)
    );

    // Reference model: queue of words still to be emitted, tagged with flags
    typedef struct {
        logic [31:0] w;
        logic        bl;
        logic        fl;
    } beat_t;

    beat_t wq[$];
    int    kblk = 0;

    function automatic logic [31:0] swap(input logic [31:0] x);
        return {x[15:0], x[31:16]};
    endfunction

    function automatic bit model_lr();
        return ((wq.size() + 7) / 8) < 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic md, input logic qr);
        bit    mlr;
        bit    acc;
        bit    bt;
        beat_t b;
        logic [31:0] ew;
        mlr = model_lr();
        rst = r; load = ld; mode = md; Q_ready = qr;
        acc = !r && ld && mlr;
        bt  = !r && (wq.size() > 0) && qr;
        @(posedge clk);
        if (r) begin
            wq.delete();
            kblk = 0;
        end else begin
            if (bt) b = wq.pop_front();
            if (acc) begin
                for (int i = 0; i < 8; i++) begin
                    b.w  = md ? swap(d[i]) : d[i];
                    b.bl = (i == 7);
                    b.fl = (i == 7) && (kblk % 8 == 7);
                    wq.push_back(b);
                end
                kblk++;
            end
        end
        @(negedge clk);
        ew = (wq.size() > 0) ? wq[0].w : 32'h0;
        chk("m_valid", {31'b0, Q_valid}, {31'b0, wq.size() > 0});
        chk("m_Q", Q, ew);
        chk("m_block_last", {31'b0, block_last}, {31'b0, (wq.size() > 0) && wq[0].bl});
        chk("m_frame_last", {31'b0, frame_last}, {31'b0, (wq.size() > 0) && wq[0].fl});
        chk("m_load_ready", {31'b0, load_ready}, {31'b0, model_lr()});
    endtask

    typedef struct {
        logic        r, ld, md, qr, dset;
        logic        ev;
        logic [31:0] eq;
        logic        ebl;
        logic        elr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic ld, input logic md,
                                input logic qr, input logic ds, input logic ev,
                                input logic [31:0] eq, input logic ebl, input logic elr);
        vec_t v;
        v.r = r; v.ld = ld; v.md = md; v.qr = qr; v.dset = ds;
        v.ev = ev; v.eq = eq; v.ebl = ebl; v.elr = elr;
        return v;
    endfunction

    logic [31:0] a_blk [8];
    logic [31:0] b_blk [8];
    logic [31:0] bs    [8];
    logic [31:0] c_blk [8];
    vec_t        tbl   [19];

    initial begin
        int run;
        int flc;
        int flbeat;
        int beats;
        int acc;
        bit ld;
        for (int i = 0; i < 8; i++) begin
            a_blk[i] = 32'h0010_0000 + i * 32'h0001_0001;
            b_blk[i] = 32'h1000_2000 + i * 32'h0001_0001;
            bs[i]    = 32'h2000_1000 + i * 32'h0001_0001;
            c_blk[i] = $urandom;
        end
        b_blk[0] = 32'h1234_5678;
        bs[0]    = 32'h5678_1234;

        // Tests 1 and 2: single block, then IFFT swap with mode dropped after load
        tbl[0] = mk(1, 0, 0, 1, 0, 0, 32'h0, 0, 1);
        tbl[1] = mk(0, 1, 0, 1, 0, 1, a_blk[0], 0, 1);
        for (int i = 1; i < 8; i++)
            tbl[1 + i] = mk(0, 0, 0, 1, 0, 1, a_blk[i], i == 7, 1);
        tbl[9]  = mk(0, 0, 0, 1, 0, 0, 32'h0, 0, 1);
        tbl[10] = mk(0, 1, 1, 1, 1, 1, 32'h5678_1234, 0, 1);
        for (int i = 1; i < 8; i++)
            tbl[10 + i] = mk(0, 0, 0, 1, 1, 1, bs[i], i == 7, 1);
        tbl[18] = mk(0, 0, 0, 1, 0, 0, 32'h0, 0, 1);

        rst = 1'b1; load = 1'b0; mode = 1'b0; Q_ready = 1'b1;
        d = a_blk;
        for (int i = 0; i < 19; i++) begin
            d = tbl[i].dset ? b_blk : a_blk;
            step(tbl[i].r, tbl[i].ld, tbl[i].md, tbl[i].qr);
            chk("tbl_valid", {31'b0, Q_valid}, {31'b0, tbl[i].ev});
            chk("tbl_Q", Q, tbl[i].eq);
            chk("tbl_block_last", {31'b0, block_last}, {31'b0, tbl[i].ebl});
            chk("tbl_load_ready", {31'b0, load_ready}, {31'b0, tbl[i].elr});
        end

        // Test 3: back-to-back blocks, B loaded two cycles after A
        step(1, 0, 0, 1);
        d = a_blk;
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        d = b_blk;
        step(0, 1, 0, 1);
        chk("b2b_lr_low", {31'b0, load_ready}, 32'h0);
        run = 3;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 1);
            if (Q_valid && Q == b_blk[0])
                chk("b2b_lr_back", {31'b0, load_ready}, 32'h1);
            if (!Q_valid) break;
            run++;
        end
        chk("b2b_run", run, 16);

        // Test 4: three stall cycles at idx 4
        step(1, 0, 0, 1);
        d = a_blk;
        step(0, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("bp_hold_Q", Q, a_blk[4]);
            chk("bp_hold_bl", {31'b0, block_last}, 32'h0);
        end
        for (int i = 5; i < 8; i++) begin
            step(0, 0, 0, 1);
            chk("bp_resume_Q", Q, a_blk[i]);
        end
        step(0, 0, 0, 1);
        chk("bp_done", {31'b0, Q_valid}, 32'h0);

        // Test 5: nine blocks, frame_last only on the 64th word
        step(1, 0, 0, 1);
        acc = 0; flc = 0; flbeat = -1; beats = 0;
        for (int c = 0; c < 120; c++) begin
            ld = (acc < 9);
            if (ld && model_lr()) acc++;
            for (int i = 0; i < 8; i++) d[i] = $urandom;
            step(0, ld, 1'b0, 1'b1);
            if (Q_valid) begin
                if (frame_last) begin
                    flc++;
                    flbeat = beats;
                end
                beats++;
            end
        end
        chk("frame_count", flc, 1);
        chk("frame_beat", flbeat, 63);
        chk("frame_beats", beats, 72);

        // Test 6: reset at idx 3 with the shadow bank full
        step(1, 0, 0, 1);
        d = a_blk;
        step(0, 1, 0, 1);
        d = b_blk;
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_pre_Q", Q, a_blk[3]);
        chk("rst_pre_lr", {31'b0, load_ready}, 32'h0);
        step(1, 1, 0, 1);
        chk("rst_valid", {31'b0, Q_valid}, 32'h0);
        chk("rst_lr", {31'b0, load_ready}, 32'h1);
        d = c_blk;
        step(0, 1, 0, 1);
        chk("rst_reload_Q", Q, c_blk[0]);

        // Random traffic against the queue model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 8; i++) d[i] = $urandom;
            step(($urandom % 151) == 0, ($urandom % 3) == 0,
                 1'($urandom), ($urandom % 4) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
